// File: rtl/packet_buf_sched.sv
// Purpose: rotates three packet buffers between the snooper, the CPU and the forwarder in strict arrival order.
// Latency: each pulse takes effect at the next clk edge; new grants are visible in the cycle after that edge.
// Backpressure: sn_grant stays low while all three buffers are busy; pulses that arrive while their grant is low are ignored.
module packet_buf_sched #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  sn_grant,
  output logic [1:0]            sn_sel,
  input  logic                  sn_done,
  input  logic [ADDR_WIDTH+3:0] sn_len,
  output logic                  cpu_grant,
  output logic [1:0]            cpu_sel,
  output logic [ADDR_WIDTH+3:0] cpu_len,
  input  logic                  cpu_accept,
  input  logic                  cpu_reject,
  output logic                  fwd_grant,
  output logic [1:0]            fwd_sel,
  output logic [ADDR_WIDTH+3:0] fwd_len,
  input  logic                  fwd_done,
  output logic [31:0]           n_accept,
  output logic [31:0]           n_reject
);

  localparam int LW = ADDR_WIDTH + 4;

  typedef enum logic [1:0] {
    BUF_EMPTY  = 2'd0,
    BUF_READY  = 2'd1,
    BUF_ACCEPT = 2'd2,
    BUF_SKIP   = 2'd3
  } buf_state_t;

  buf_state_t        state_q [3];
  buf_state_t        state_d [3];
  logic [LW-1:0]     len_q   [3];
  logic [1:0]        sn_ptr;
  logic [1:0]        cpu_ptr;
  logic [1:0]        fwd_ptr;
  logic [31:0]       accept_cnt;
  logic [31:0]       reject_cnt;

  buf_state_t        sn_st;
  buf_state_t        cpu_st;
  buf_state_t        fwd_st;

  logic              sn_fire;
  logic              sn_zero;
  logic              cpu_acc_fire;
  logic              cpu_rej_fire;
  logic              cpu_pass;
  logic              fwd_fire;
  logic              fwd_pass;
  logic [1:0]        rej_inc;

  // Pointers walk 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ring_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Explicit 3-way mux keeps pointer value 3 (never reached) well defined.
  function automatic buf_state_t state_at(input logic [1:0] p, input buf_state_t s0,
                                          input buf_state_t s1, input buf_state_t s2);
    case (p)
      2'd0:    return s0;
      2'd1:    return s1;
      2'd2:    return s2;
      default: return BUF_EMPTY;
    endcase
  endfunction

  function automatic logic [LW-1:0] len_at(input logic [1:0] p, input logic [LW-1:0] l0,
                                           input logic [LW-1:0] l1, input logic [LW-1:0] l2);
    case (p)
      2'd0:    return l0;
      2'd1:    return l1;
      2'd2:    return l2;
      default: return '0;
    endcase
  endfunction

  // Grant/select/length decode from registers only (reset forces the grants low).
  always_comb begin
    sn_st     = state_at(sn_ptr,  state_q[0], state_q[1], state_q[2]);
    cpu_st    = state_at(cpu_ptr, state_q[0], state_q[1], state_q[2]);
    fwd_st    = state_at(fwd_ptr, state_q[0], state_q[1], state_q[2]);
    sn_grant  = !rst && (sn_st  == BUF_EMPTY);
    cpu_grant = !rst && (cpu_st == BUF_READY);
    fwd_grant = !rst && (fwd_st == BUF_ACCEPT);
    sn_sel    = sn_ptr;
    cpu_sel   = cpu_ptr;
    fwd_sel   = fwd_ptr;
    cpu_len   = len_at(cpu_ptr, len_q[0], len_q[1], len_q[2]);
    fwd_len   = len_at(fwd_ptr, len_q[0], len_q[1], len_q[2]);
    n_accept  = accept_cnt;
    n_reject  = reject_cnt;
  end

  // Qualify agent pulses with their grants; reject wins over a simultaneous accept.
  always_comb begin
    sn_zero      = (sn_len == '0);
    sn_fire      = sn_done && sn_grant;
    cpu_rej_fire = cpu_reject && cpu_grant;
    cpu_acc_fire = cpu_accept && !cpu_reject && cpu_grant;
    // A zero-length packet is already SKIP when the CPU pointer reaches it, so
    // the CPU pointer steps over it. When cpu_ptr == sn_ptr the SKIP buffer is
    // one the CPU already decided on (ring full), so it must stay put.
    cpu_pass     = (cpu_st == BUF_SKIP) && (cpu_ptr != sn_ptr);
    fwd_fire     = fwd_done && fwd_grant;
    fwd_pass     = (fwd_st == BUF_SKIP);
    rej_inc      = {1'b0, sn_fire && sn_zero} + {1'b0, cpu_rej_fire};
  end

  // Next state per buffer; the three agents always own distinct buffers.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      if (sn_fire && (sn_ptr == 2'(i))) begin
        state_d[i] = sn_zero ? BUF_SKIP : BUF_READY;
      end
      if (cpu_rej_fire && (cpu_ptr == 2'(i))) begin
        state_d[i] = BUF_SKIP;
      end else if (cpu_acc_fire && (cpu_ptr == 2'(i))) begin
        state_d[i] = BUF_ACCEPT;
      end
      if ((fwd_fire || fwd_pass) && (fwd_ptr == 2'(i))) begin
        state_d[i] = BUF_EMPTY;
      end
    end
  end

  // Buffer states, lengths, pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= BUF_EMPTY;
        len_q[i]   <= '0;
      end
      sn_ptr     <= 2'd0;
      cpu_ptr    <= 2'd0;
      fwd_ptr    <= 2'd0;
      accept_cnt <= '0;
      reject_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        if (sn_fire && !sn_zero && (sn_ptr == 2'(i))) begin
          len_q[i] <= sn_len;
        end
      end
      if (sn_fire) begin
        sn_ptr <= ring_next(sn_ptr);
      end
      if (cpu_rej_fire || cpu_acc_fire || cpu_pass) begin
        cpu_ptr <= ring_next(cpu_ptr);
      end
      if (fwd_fire || fwd_pass) begin
        fwd_ptr <= ring_next(fwd_ptr);
      end
      if (cpu_acc_fire) begin
        accept_cnt <= accept_cnt + 32'd1;
      end
      reject_cnt <= reject_cnt + 32'(rej_inc);
    end
  end

endmodule

// File: tb/tb_packet_buf_sched.sv
module tb_packet_buf_sched;

  localparam int AW = 10;
  localparam int LW = AW + 4;

  localparam int P_READY = 0;
  localparam int P_ACC   = 1;
  localparam int P_SKIP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sn_grant;
  logic [1:0]    sn_sel;
  logic          sn_done = 1'b0;
  logic [LW-1:0] sn_len = '0;
  logic          cpu_grant;
  logic [1:0]    cpu_sel;
  logic [LW-1:0] cpu_len;
  logic          cpu_accept = 1'b0;
  logic          cpu_reject = 1'b0;
  logic          fwd_grant;
  logic [1:0]    fwd_sel;
  logic [LW-1:0] fwd_len;
  logic          fwd_done = 1'b0;
  logic [31:0]   n_accept;
  logic [31:0]   n_reject;

  always #5 clk = ~clk;

  packet_buf_sched #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .sn_grant(sn_grant), .sn_sel(sn_sel), .sn_done(sn_done), .sn_len(sn_len),
    .cpu_grant(cpu_grant), .cpu_sel(cpu_sel), .cpu_len(cpu_len),
    .cpu_accept(cpu_accept), .cpu_reject(cpu_reject),
    .fwd_grant(fwd_grant), .fwd_sel(fwd_sel), .fwd_len(fwd_len), .fwd_done(fwd_done),
    .n_accept(n_accept), .n_reject(n_reject)
  );

  typedef struct {
    bit          sn_g;
    bit          cpu_g;
    bit          fwd_g;
    int          sn_s;
    int          cpu_s;
    int          fwd_s;
    int          cpu_l;
    int          fwd_l;
    logic [31:0] na;
    logic [31:0] nr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model in packet-sequence space: packet k lives in buffer k%3.
  // adm = packets admitted, cp = next packet for the CPU, fp = next packet to leave.
  int          adm, cp, fp;
  int          plen [8];
  int          pst  [8];
  logic [31:0] m_na, m_nr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit m_sn_g(input bit r);
    return !r && ((adm - fp) < 3);
  endfunction

  function automatic bit m_cpu_g(input bit r);
    return !r && (cp < adm) && (pst[cp % 8] == P_READY);
  endfunction

  function automatic bit m_fwd_g(input bit r);
    return !r && (fp < adm) && (pst[fp % 8] == P_ACC);
  endfunction

  task automatic model_edge(input bit r, input bit snd, input int len,
                            input bit acc, input bit rej, input bit fd);
    bit gs, gc, gf, csk, fsk;
    if (r) begin
      adm = 0; cp = 0; fp = 0; m_na = 0; m_nr = 0;
      return;
    end
    gs  = m_sn_g(1'b0);
    gc  = m_cpu_g(1'b0);
    gf  = m_fwd_g(1'b0);
    csk = (cp < adm) && (pst[cp % 8] == P_SKIP);
    fsk = (fp < adm) && (pst[fp % 8] == P_SKIP);
    if (rej && gc) begin
      pst[cp % 8] = P_SKIP; m_nr++; cp++;
    end else if (acc && gc) begin
      pst[cp % 8] = P_ACC; m_na++; cp++;
    end else if (csk) begin
      cp++;
    end
    if ((fd && gf) || fsk) fp++;
    if (snd && gs) begin
      plen[adm % 8] = len;
      pst[adm % 8]  = (len == 0) ? P_SKIP : P_READY;
      if (len == 0) m_nr++;
      adm++;
    end
  endtask

  function automatic exp_t snap(input bit r);
    exp_t e;
    e.sn_g  = m_sn_g(r);
    e.cpu_g = m_cpu_g(r);
    e.fwd_g = m_fwd_g(r);
    e.sn_s  = adm % 3;
    e.cpu_s = cp % 3;
    e.fwd_s = fp % 3;
    e.cpu_l = e.cpu_g ? plen[cp % 8] : 0;
    e.fwd_l = e.fwd_g ? plen[fp % 8] : 0;
    e.na    = m_na;
    e.nr    = m_nr;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit snd, input int len,
                     input bit acc, input bit rej, input bit fd);
    @(negedge clk);
    rst = r; sn_done = snd; sn_len = LW'(len);
    cpu_accept = acc; cpu_reject = rej; fwd_done = fd;
    @(posedge clk);
    model_edge(r, snd, len, acc, rej, fd);
    exp_q.push_back(snap(r));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected snapshot per clock edge, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_sn_grant",  32'(sn_grant),  32'(e.sn_g));
        chk("mon_cpu_grant", 32'(cpu_grant), 32'(e.cpu_g));
        chk("mon_fwd_grant", 32'(fwd_grant), 32'(e.fwd_g));
        chk("mon_sn_sel",    32'(sn_sel),    32'(e.sn_s));
        chk("mon_cpu_sel",   32'(cpu_sel),   32'(e.cpu_s));
        chk("mon_fwd_sel",   32'(fwd_sel),   32'(e.fwd_s));
        chk("mon_n_accept",  n_accept,       e.na);
        chk("mon_n_reject",  n_reject,       e.nr);
        if (e.cpu_g) chk("mon_cpu_len", 32'(cpu_len), 32'(e.cpu_l));
        if (e.fwd_g) chk("mon_fwd_len", 32'(fwd_len), 32'(e.fwd_l));
      end
    end
  end

  initial begin
    int wait_cnt;
    adm = 0; cp = 0; fp = 0; m_na = 0; m_nr = 0;
    for (int i = 0; i < 8; i++) begin plen[i] = 0; pst[i] = P_READY; end

    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(); #2;
    chk("rst_sn_grant", 32'(sn_grant), 1);
    chk("rst_sn_sel", 32'(sn_sel), 0);
    chk("rst_cpu_grant", 32'(cpu_grant), 0);
    chk("rst_fwd_grant", 32'(fwd_grant), 0);
    chk("rst_n_accept", n_accept, 0);
    chk("rst_n_reject", n_reject, 0);

    // Single packet path
    cyc(0, 1, 64, 0, 0, 0); #2;
    chk("sp_cpu_grant", 32'(cpu_grant), 1);
    chk("sp_cpu_sel", 32'(cpu_sel), 0);
    chk("sp_cpu_len", 32'(cpu_len), 64);
    chk("sp_sn_sel", 32'(sn_sel), 1);
    cyc(0, 0, 0, 1, 0, 0); #2;
    chk("sp_fwd_grant", 32'(fwd_grant), 1);
    chk("sp_fwd_sel", 32'(fwd_sel), 0);
    chk("sp_fwd_len", 32'(fwd_len), 64);
    chk("sp_n_accept", n_accept, 1);
    cyc(0, 0, 0, 0, 0, 1); #2;
    chk("sp_fwd_grant_off", 32'(fwd_grant), 0);
    chk("sp_fwd_sel_next", 32'(fwd_sel), 1);

    // Reject and skip (buffer 1)
    cyc(0, 1, 60, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0); #2;
    chk("rj_n_reject", n_reject, 1);
    chk("rj_fwd_grant", 32'(fwd_grant), 0);
    idle(); #2;
    chk("rj_fwd_sel", 32'(fwd_sel), 2);
    chk("rj_fwd_grant2", 32'(fwd_grant), 0);
    cyc(0, 1, 0, 0, 0, 0); #2;
    chk("zl_n_reject", n_reject, 2);
    chk("zl_cpu_grant", 32'(cpu_grant), 0);
    idle(); idle(); #2;
    chk("zl_cpu_grant2", 32'(cpu_grant), 0);
    chk("zl_fwd_sel", 32'(fwd_sel), 0);

    // Full condition
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 60, 0, 0, 0);
    cyc(0, 1, 100, 0, 0, 0);
    cyc(0, 1, 1500, 0, 0, 0); #2;
    chk("full_sn_grant", 32'(sn_grant), 0);
    chk("full_cpu_len0", 32'(cpu_len), 60);
    cyc(0, 0, 0, 1, 0, 0); #2;
    chk("full_cpu_len1", 32'(cpu_len), 100);
    chk("full_sn_grant2", 32'(sn_grant), 0);
    cyc(0, 0, 0, 0, 0, 1); #2;
    chk("full_sn_grant3", 32'(sn_grant), 1);
    chk("full_sn_sel", 32'(sn_sel), 0);
    cyc(0, 0, 0, 1, 0, 0); #2;
    chk("full_cpu_len2", 32'(cpu_len), 1500);

    // Simultaneous: buf0 ACCEPT, buf1 READY, buf2 EMPTY
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 10, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 20, 0, 0, 0);
    cyc(0, 1, 80, 0, 1, 1); #2;
    chk("sim_fwd_sel", 32'(fwd_sel), 1);
    chk("sim_cpu_sel", 32'(cpu_sel), 2);
    chk("sim_n_reject", n_reject, 1);
    idle(); #2;
    chk("sim_fwd_sel2", 32'(fwd_sel), 2);
    chk("sim_cpu_grant", 32'(cpu_grant), 1);
    chk("sim_cpu_len", 32'(cpu_len), 80);
    cyc(0, 0, 0, 1, 1, 0); #2;
    chk("both_n_reject", n_reject, 2);
    chk("both_n_accept", n_accept, 1);

    // Ignored pulses (everything drained, grants low)
    idle();
    cyc(0, 0, 0, 1, 0, 1); #2;
    chk("ign_n_accept", n_accept, 1);
    chk("ign_n_reject", n_reject, 2);
    chk("ign_fwd_sel", 32'(fwd_sel), 0);
    chk("ign_cpu_grant", 32'(cpu_grant), 0);

    // Reset with all buffers busy
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 1, 6, 1, 0, 0);
    cyc(0, 1, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(); #2;
    chk("abort_sn_grant", 32'(sn_grant), 1);
    chk("abort_sn_sel", 32'(sn_sel), 0);
    chk("abort_cpu_grant", 32'(cpu_grant), 0);
    chk("abort_fwd_grant", 32'(fwd_grant), 0);
    chk("abort_n_accept", n_accept, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, s, a, j, f;
      int l;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 2000));
      a = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 2) == 0);
      cyc(r, s, l, a, j, f);
    end
    idle();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    chk("drain_queue", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
